// File: rtl/avalon_packetizer_if.sv
// Avalon-ST packet bus: data plus SOP/EOP framing and empty-byte count on the EOP beat.
// Latency: none, this is a pure signal bundle.
// Backpressure: the sink drives rdy; a beat transfers when valid & rdy.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 8
);
  localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_packetizer.sv
// Frames a raw word stream into Avalon-ST packets from per-packet byte-length commands.
// Latency: 0 cycles data_in -> packet_msg while sending; first beat the cycle after length accept.
// Backpressure: packet_msg.rdy passes straight to data_in_rdy; optional counters via AVALON_PACKETIZER_STATS_EN.
module avalon_packetizer #(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int MAX_LEN_BYTES       = 1024,
  localparam int B          = DATA_WIDTH_IN_BYTES,
  localparam int LEN_W      = $clog2(MAX_LEN_BYTES + 1),
  localparam int EMPTY_W    = $clog2(B),
  localparam int MAX_WORDS  = (MAX_LEN_BYTES + B - 1) / B,
  localparam int WCNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             len_valid,
  input  logic [LEN_W-1:0] len_bytes,
  output logic             len_rdy,
  input  logic [B*8-1:0]   data_in,
  input  logic             data_in_valid,
  output logic             data_in_rdy,
  avalon_st_if.master      packet_msg,
  output logic             len_err
`ifdef AVALON_PACKETIZER_STATS_EN
  ,
  output logic [31:0]      packets_sent,
  output logic [15:0]      len_errs
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   words_total_q, words_total_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [EMPTY_W-1:0]  last_empty_q, last_empty_d;
  logic                len_err_q, len_err_d;

  // Length rounded up to a whole number of beats before the shift.
  logic [LEN_W:0]      len_round;
  logic                len_bad;
  logic                last_beat;
  logic                beat_fire;

  assign len_round = {1'b0, len_bytes} + (LEN_W + 1)'(B - 1);
  assign len_bad   = (len_bytes == '0) || (len_bytes > LEN_W'(MAX_LEN_BYTES));
  assign last_beat = (word_cnt_q == words_total_q - WCNT_W'(1));
  assign beat_fire = (state_q == SEND) && data_in_valid && packet_msg.rdy;

  // Next-state: accept/drop length commands in IDLE, count beats in SEND.
  always_comb begin
    state_d       = state_q;
    words_total_d = words_total_q;
    word_cnt_d    = word_cnt_q;
    last_empty_d  = last_empty_q;
    len_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (len_valid) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            words_total_d = WCNT_W'(len_round >> EMPTY_W);
            // Unused bytes in the final beat: (-len) mod B.
            last_empty_d  = '0 - len_bytes[EMPTY_W-1:0];
            word_cnt_d    = '0;
            state_d       = SEND;
          end
        end
      end
      SEND: begin
        if (beat_fire) begin
          word_cnt_d = word_cnt_q + WCNT_W'(1);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: quiet in IDLE, combinational pass-through with framing in SEND.
  always_comb begin
    len_rdy          = 1'b0;
    data_in_rdy      = 1'b0;
    packet_msg.valid = 1'b0;
    packet_msg.data  = '0;
    packet_msg.sop   = 1'b0;
    packet_msg.eop   = 1'b0;
    packet_msg.empty = '0;
    case (state_q)
      IDLE: len_rdy = 1'b1;
      SEND: begin
        packet_msg.valid = data_in_valid;
        packet_msg.data  = data_in;
        data_in_rdy      = packet_msg.rdy;
        packet_msg.sop   = data_in_valid && (word_cnt_q == '0);
        packet_msg.eop   = data_in_valid && last_beat;
        packet_msg.empty = (data_in_valid && last_beat) ? last_empty_q : '0;
      end
      default: len_rdy = 1'b0;
    endcase
  end

  assign len_err = len_err_q;

  // State and packet-descriptor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      words_total_q <= '0;
      word_cnt_q    <= '0;
      last_empty_q  <= '0;
      len_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      words_total_q <= words_total_d;
      word_cnt_q    <= word_cnt_d;
      last_empty_q  <= last_empty_d;
      len_err_q     <= len_err_d;
    end
  end

`ifdef AVALON_PACKETIZER_STATS_EN
  logic [31:0] packets_sent_q, packets_sent_d;
  logic [15:0] len_errs_q, len_errs_d;

  // Free-running wrap-around counters of completed packets and dropped lengths.
  always_comb begin
    packets_sent_d = packets_sent_q;
    len_errs_d     = len_errs_q;
    if (beat_fire && last_beat) begin
      packets_sent_d = packets_sent_q + 32'd1;
    end
    if (len_err_d) begin
      len_errs_d = len_errs_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      packets_sent_q <= '0;
      len_errs_q     <= '0;
    end else begin
      packets_sent_q <= packets_sent_d;
      len_errs_q     <= len_errs_d;
    end
  end

  assign packets_sent = packets_sent_q;
  assign len_errs     = len_errs_q;
`endif

endmodule

// File: tb/tb_avalon_packetizer.sv
// Randomized scoreboard bench for avalon_packetizer with directed framing cases.
// Latency: expects first beat one cycle after length accept, zero-cycle pass-through.
// Backpressure: sink rdy is directed or randomized; stalls must not lose or duplicate words.
module tb_avalon_packetizer;
  localparam int B     = 8;
  localparam int MAXL  = 1024;
  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             len_valid;
  logic [LEN_W-1:0] len_bytes;
  logic             len_rdy;
  logic [B*8-1:0]   data_in;
  logic             data_in_valid;
  logic             data_in_rdy;
  logic             len_err;
`ifdef AVALON_PACKETIZER_STATS_EN
  logic [31:0]      packets_sent;
  logic [15:0]      len_errs;
`endif

  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(B)) pm ();

  avalon_packetizer #(.DATA_WIDTH_IN_BYTES(B), .MAX_LEN_BYTES(MAXL)) dut (
    .clk           (clk),
    .rst           (rst),
    .len_valid     (len_valid),
    .len_bytes     (len_bytes),
    .len_rdy       (len_rdy),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_rdy   (data_in_rdy),
    .packet_msg    (pm),
    .len_err       (len_err)
`ifdef AVALON_PACKETIZER_STATS_EN
    ,
    .packets_sent  (packets_sent),
    .len_errs      (len_errs)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] pay[$];
  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int exp_err_pulses = 0;
  int exp_pkts = 0;
  int exp_errs = 0;
  bit rand_rdy = 1'b0;
  bit rand_gap = 1'b0;
  logic rnd_rdy = 1'b1;
  logic dir_rdy;

  assign pm.rdy = rand_rdy ? rnd_rdy : dir_rdy;

  // Random sink backpressure.
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every output beat and checks idle/stall rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (pm.valid && pm.rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got data=%h sop=%b eop=%b empty=%0d, none expected",
                   pm.data, pm.sop, pm.eop, pm.empty);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (pm.data !== e.data || pm.sop !== e.sop || pm.eop !== e.eop || pm.empty !== e.empty) begin
            errors++;
            $display("FAIL beat got data=%h sop=%b eop=%b empty=%0d want data=%h sop=%b eop=%b empty=%0d",
                     pm.data, pm.sop, pm.eop, pm.empty, e.data, e.sop, e.eop, e.empty);
          end
        end
      end
      if (len_rdy) begin
        checks++;
        if (data_in_rdy !== 1'b0 || pm.valid !== 1'b0 || pm.sop !== 1'b0 || pm.eop !== 1'b0 ||
            pm.empty !== 3'd0 || pm.data !== 64'd0) begin
          errors++;
          $display("FAIL idle_outputs got data_in_rdy=%b valid=%b sop=%b eop=%b empty=%0d data=%h want all 0",
                   data_in_rdy, pm.valid, pm.sop, pm.eop, pm.empty, pm.data);
        end
      end
      if (pm.rdy === 1'b0) begin
        checks++;
        if (data_in_rdy !== 1'b0) begin
          errors++;
          $display("FAIL stall_data_in_rdy got %b want 0", data_in_rdy);
        end
      end
      if (len_err === 1'b1) err_pulses++;
    end
  end

  // Reference model: split L bytes into ceil(L/B) beats, EOP carries the unused byte count.
  task automatic build_pkt(input int L);
    int nw;
    int emp;
    beat_t b;
    logic [63:0] w;
    nw  = (L + B - 1) / B;
    emp = nw * B - L;
    pay.delete();
    for (int i = 0; i < nw; i++) begin
      w = {$urandom, $urandom};
      pay.push_back(w);
      b.data  = w;
      b.sop   = (i == 0);
      b.eop   = (i == nw - 1);
      b.empty = (i == nw - 1) ? 3'(emp) : 3'd0;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_len(input int L, output bit ok);
    int t;
    t = 0;
    len_bytes = LEN_W'(L);
    len_valid = 1'b1;
    @(negedge clk);
    while (len_rdy !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL len_accept_timeout got len_rdy=%b want 1 within 2000 cycles", len_rdy);
      len_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      len_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic send_data(input int stall_at, input int limit);
    int idx;
    int t;
    bit fire;
    bit stalled;
    idx = 0;
    t = 0;
    stalled = 1'b0;
    while (idx < pay.size() && idx < limit) begin
      data_in = pay[idx];
      if (idx == stall_at && !stalled) begin
        stalled = 1'b1;
        data_in_valid = 1'b1;
        dir_rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (data_in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got data_in_rdy=%b want 0", data_in_rdy);
          end
          @(posedge clk);
          #1;
        end
        dir_rdy = 1'b1;
      end
      data_in_valid = rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      fire = data_in_valid && data_in_rdy;
      @(posedge clk);
      #1;
      if (fire) idx++;
      else t++;
      if (t > 2000) begin
        checks++;
        errors++;
        $display("FAIL data_timeout got %0d words sent want %0d", idx, pay.size());
        break;
      end
    end
  endtask

  task automatic run_pkt(input int L, input int stall_at);
    bit ok;
    if (L < 1 || L > MAXL) begin
      send_len(L, ok);
      if (ok) begin
        exp_err_pulses++;
        exp_errs++;
        @(negedge clk);
        checks++;
        if (len_err !== 1'b1 || len_rdy !== 1'b1) begin
          errors++;
          $display("FAIL len_err_pulse len=%0d got len_err=%b len_rdy=%b want 1 1", L, len_err, len_rdy);
        end
        @(negedge clk);
        checks++;
        if (len_err !== 1'b0) begin
          errors++;
          $display("FAIL len_err_width len=%0d got %b want 0", L, len_err);
        end
        @(posedge clk);
        #1;
      end
    end else begin
      build_pkt(L);
      fork
        send_len(L, ok);
        send_data(stall_at, 1 << 20);
      join
      exp_pkts++;
    end
  endtask

  initial begin
    bit ok;
    int L;
    int r;
    rst = 1'b1;
    len_valid = 1'b0;
    len_bytes = '0;
    data_in = '0;
    data_in_valid = 1'b0;
    dir_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (len_rdy !== 1'b1 || data_in_rdy !== 1'b0 || len_err !== 1'b0 || pm.valid !== 1'b0 ||
        pm.sop !== 1'b0 || pm.eop !== 1'b0 || pm.empty !== 3'd0 || pm.data !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got len_rdy=%b data_in_rdy=%b len_err=%b valid=%b sop=%b eop=%b empty=%0d data=%h",
               len_rdy, data_in_rdy, len_err, pm.valid, pm.sop, pm.eop, pm.empty, pm.data);
    end
`ifdef AVALON_PACKETIZER_STATS_EN
    checks++;
    if (packets_sent !== 32'd0 || len_errs !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats got packets_sent=%0d len_errs=%0d want 0 0", packets_sent, len_errs);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    dir_rdy = 1'b1;

    // Directed framing cases with the sink always ready.
    run_pkt(20, -1);
    run_pkt(16, -1);
    run_pkt(5, -1);
    run_pkt(24, 1);
    run_pkt(0, -1);
    run_pkt(1025, -1);
`ifdef AVALON_PACKETIZER_STATS_EN
    checks++;
    if (len_errs !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL stats_len_errs got %0d want %0d", len_errs, exp_errs);
    end
`endif

    // Reset in the middle of a 4-beat packet after two beats.
    build_pkt(32);
    fork
      send_len(32, ok);
      send_data(-1, 2);
    join
    rst = 1'b1;
    data_in_valid = 1'b0;
    dir_rdy = 1'b0;
    exp_q.delete();
    exp_pkts = 0;
    exp_errs = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_valid = 1'b1;
    dir_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (len_rdy !== 1'b1 || pm.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midpkt got len_rdy=%b valid=%b want 1 0", len_rdy, pm.valid);
    end
    @(posedge clk);
    #1;
    run_pkt(8, -1);

    // Randomized traffic with random sink stalls and source gaps.
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 19);
      case (r)
        0:       L = 0;
        1:       L = $urandom_range(MAXL + 1, 2047);
        2:       L = MAXL;
        3:       L = 1;
        default: L = $urandom_range(1, 200);
      endcase
      run_pkt(L, -1);
    end
    rand_rdy = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d beats left want 0", exp_q.size());
    end
    checks++;
    if (err_pulses != exp_err_pulses) begin
      errors++;
      $display("FAIL len_err_count got %0d want %0d", err_pulses, exp_err_pulses);
    end
`ifdef AVALON_PACKETIZER_STATS_EN
    checks++;
    if (packets_sent !== 32'(exp_pkts) || len_errs !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL stats_final got packets_sent=%0d len_errs=%0d want %0d %0d",
               packets_sent, len_errs, exp_pkts, exp_errs);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_packetizer.md
# avalon_packetizer

Source-side framer for the team's Avalon-ST links. It takes a per-packet byte-length command plus a raw, unframed word stream and drives a well-formed Avalon-ST packet on `avalon_st_if`: SOP on the first beat, EOP on the last, and `empty` on the EOP beat derived from the length. It is the transmit counterpart of the packet enforcer and sits between payload producers and any Avalon-ST sink.

## Interface
Parameters:
- `DATA_WIDTH_IN_BYTES`, default 8: bytes per beat (B). Must be a power of 2, ≥ 2.
- `MAX_LEN_BYTES`, default 1024: largest legal packet length in bytes.
- Derived: `LEN_W` = $clog2(MAX_LEN_BYTES+1); `EMPTY_W` = $clog2(DATA_WIDTH_IN_BYTES); `WCNT_W` = $clog2(ceil(MAX_LEN_BYTES/B)+1).

Ports:
- `clk`: input, 1 bit. Single clock; all logic is on its rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `len_valid`: input, 1 bit. Length command valid.
- `len_bytes`: input, `LEN_W` bits. Packet length in bytes.
- `len_rdy`: output, 1 bit. Length command accepted when `len_valid & len_rdy`.
- `data_in`: input, B*8 bits. Raw payload word.
- `data_in_valid`: input, 1 bit. Payload word valid.
- `data_in_rdy`: output, 1 bit. Payload word consumed when `data_in_valid & data_in_rdy`.
- `packet_msg`: `avalon_st_if.master`. Framed output: data, valid, rdy (input), sop, eop, empty.
- `len_err`: output, 1 bit. One-cycle pulse when an illegal length command is dropped.

## Operation
- FSM with two states.
  - IDLE: `len_rdy`=1, `data_in_rdy`=0, `packet_msg.valid/sop/eop`=0, `packet_msg.data`='0, `empty`=0.
  - SEND: `len_rdy`=0.
- IDLE, on `len_valid`:
  - `len_bytes`==0 or `len_bytes` > `MAX_LEN_BYTES`: command is consumed and dropped, `len_err` pulses for 1 cycle, FSM stays in IDLE.
  - Otherwise: register `words_total` = ceil(len/B) and `last_empty` = words_total*B − len. Clear `word_cnt`. Go to SEND.
- SEND is a combinational pass-through:
  - `packet_msg.valid` = `data_in_valid`.
  - `data_in_rdy` = `packet_msg.rdy`.
  - `packet_msg.data` = `data_in`.
  - `sop` = valid & (`word_cnt`==0).
  - `eop` = valid & (`word_cnt`==`words_total`−1).
  - `empty` = `eop` ? `last_empty` : 0.
- Beat handshake is `packet_msg.valid & packet_msg.rdy`.
  - On a beat handshake, `word_cnt` increments.
  - On an EOP beat handshake, go to IDLE.
- Single-word packets assert sop and eop on the same beat.
- When `packet_msg.rdy` is low, `word_cnt` and FSM hold. `data_in_rdy` is low, so no word is lost.
- Payload words presented in IDLE are not consumed.
- Generated packets always have exactly one SOP, exactly one EOP, and no valid beats outside a packet.

## Timing
- Reset values: `len_rdy`=1 (IDLE), `len_err`=0, `data_in_rdy`=0, `packet_msg` valid/sop/eop/empty/data all 0. Counters cleared.
- Length acceptance to first beat: the first beat can be presented the cycle after acceptance. There is 0-cycle latency from `data_in` to `packet_msg` in SEND.
- Minimum inter-packet gap: 1 cycle. After the EOP handshake the FSM is in IDLE; the next length is accepted there and SEND starts the following cycle.
- `len_err` is registered and asserts the cycle after the illegal command is seen.
- Reset mid-packet: the next cycle is IDLE with outputs at reset values. The truncated packet receives no EOP; downstream enforcement handles it.
- `len_bytes` exactly equal to `MAX_LEN_BYTES` is legal.

## Configuration
- `AVALON_PACKETIZER_STATS_EN` defined:
  - Adds output `packets_sent` [31:0], which increments on every EOP beat handshake.
  - Adds output `len_errs` [15:0], which increments with every `len_err` pulse.
  - Both reset to 0 and wrap at max.
- Undefined: these ports and counters do not exist.

## Test plan
- B=8, `len_bytes`=20, rdy held 1 → 3 beats; sop on beat 0 only; eop on beat 2 with `empty`=4; back to IDLE.
- `len_bytes`=16 → 2 beats; eop on beat 1 with `empty`=0.
- `len_bytes`=5 → single beat with sop=eop=1 and `empty`=3.
- `len_bytes`=24 with `packet_msg.rdy` low for 3 cycles before beat 1 → `data_in_rdy` low for those cycles; beat 1 data unchanged; no duplicate or lost beats; eop on beat 2.
- `len_bytes`=0, then `len_bytes`=1025 → `len_err` pulses twice; no valid beats; `len_rdy` stays 1. With stats enabled, `len_errs`=2.
- `len_bytes`=32, `rst` asserted after beat 1 → next cycle is IDLE with valid=0. Then `len_bytes`=8 → one beat with sop=eop=1 and `empty`=0.
